reg_writeback: RTL and testbench
================================

# reg_writeback

Writeback stage of the 16-bit single-cycle RISC core. It merges results from the ALU and from the multi-cycle load unit into the single write port of the register file, driving `Rd`, `RW` and `wr` for exactly one write per cycle. Load results are buffered in a small in-order FIFO with backpressure. A per-register load scoreboard (`busy`) lets decode stall on registers whose load data has not yet been written.

## Interface
- `DATA_W`, 16, register data width.
- `ADDR_W`, 4, register address width (16 registers).
- `FIFO_DEPTH`, 4, load-result buffer entries (power of two, ≥2).

Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  synchronous active-high reset.
- `alu_valid`  in  1  ALU result present this cycle; never back-pressured.
- `alu_rd`  in  ADDR_W  ALU destination register.
- `alu_data`  in  DATA_W  ALU result.
- `mem_valid`  in  1  load result offered.
- `mem_rd`  in  ADDR_W  load destination register.
- `mem_data`  in  DATA_W  load data.
- `mem_ready`  out  1  load result accepted when `mem_valid && mem_ready`.
- `iss_load`  in  1  decode issues a load this cycle.
- `iss_rd`  in  ADDR_W  destination of the issued load.
- `Rd`  out  ADDR_W  register-file write address (registered).
- `RW`  out  DATA_W  register-file write data (registered).
- `wr`  out  1  register-file write enable (registered).
- `busy`  out  2^ADDR_W  bit i set while a load to register i is outstanding.

## Operation
- **Per-cycle source select** (priority order):
  1. `alu_valid` selects the ALU result.
  2. Otherwise, a non-empty FIFO selects the FIFO head, which is popped.
  3. Otherwise, an accepted `mem_valid` selects the mem input directly (bypass; not enqueued).
  4. Otherwise, no source is selected.
- **Output register:**
  - With a selected source, the next edge loads `Rd`/`RW` from it and sets `wr`=1.
  - With no selected source, `wr`=0 and `Rd`/`RW` hold.
- **Enqueue:** an accepted mem result that is not selected is pushed to the FIFO tail. Load results are written in acceptance order. ALU results may overtake queued loads.
- **Backpressure:** `mem_ready` = !rst && (count < FIFO_DEPTH). It is combinational from count only and does not look ahead at a same-cycle pop.
- **FIFO:** circular, read/write pointers one bit wider than the index for full/empty detection. Simultaneous push and pop leaves count unchanged. Pointers wrap modulo 2·FIFO_DEPTH.
- **Load tag:** the output register carries a 1-bit `is_load` tag alongside `Rd`.
- **Scoreboard:**
  - `iss_load` sets `busy[iss_rd]` on the next edge.
  - When `wr && is_load`, `busy[Rd]` clears on the edge ending that write cycle, i.e. when the register file has stored the data.
  - If set and clear hit the same index in the same cycle, set wins.
  - Decode never issues a second load to a busy register; this block does not check it.
- **Register 0:** written like any other register (the register file has no hardwired zero).

## Timing
- **Reset values:** `wr`=0, `Rd`=0, `RW`=0, `busy`=0, FIFO empty, `is_load`=0, `mem_ready`=0 while `rst` is high.
- **Reset mid-operation:** queued load results are discarded and pending `busy` bits are lost. A write registered in the cycle `rst` rises is not presented.
- **ALU latency:** ALU result in cycle N → `wr`=1 with that data in cycle N+1.
- **Load latency, idle path:** load accepted in cycle N with FIFO empty and no ALU → `wr` in cycle N+1; `busy` bit low from cycle N+2.
- **Load latency, queued:** each queued entry waits one cycle per ALU result ahead of it plus one cycle per older FIFO entry.
- **Sustained ALU traffic:** continuous `alu_valid` starves the FIFO. Once the FIFO is full, `mem_ready`=0 until an ALU bubble pops an entry; `mem_ready` returns the cycle after that pop.
- **Throughput:** at most one register-file write per cycle. No result is dropped.

## Test plan
- **Reset:** hold `rst` 2 cycles with all inputs active → `wr`=0, `Rd`=0, `RW`=0, `busy`=0, `mem_ready`=0; first cycle after → `mem_ready`=1.
- **ALU path:** `alu_valid`, rd=3, data=0x1234 in cycle 5 → cycle 6 `wr`=1, `Rd`=3, `RW`=0x1234; cycle 7 `wr`=0.
- **Load bypass + scoreboard:**
  - Stimulus: `iss_load` rd=7 in cycle 2; mem rd=7, data=0xBEEF accepted in cycle 6, no ALU.
  - Response: `busy[7]`=1 in cycles 3–7; cycle 7 `wr`=1, `Rd`=7, `RW`=0xBEEF; `busy[7]`=0 in cycle 8.
- **Contention and order:**
  - Stimulus: ALU valid in cycles 10–15; mem results A, B, C, D, E offered from cycle 10.
  - Response: A–D accepted in cycles 10–13; `mem_ready`=0 in cycles 14–15.
  - Writes: ALU writes in cycles 11–16, then A, B, C, D in cycles 17–20. E is accepted in cycle 17 and written in cycle 21.
- **Scoreboard same-index set/clear:** load write to r5 in progress in the same cycle `iss_load` rd=5 → `busy[5]` stays 1.
- **Reset mid-operation:** FIFO holding 3 entries, assert `rst` for 1 cycle → no further `wr`; `busy`=0; `mem_ready`=1 afterwards.

Source files
------------

// File: rtl/reg_writeback.sv
// rtl/reg_writeback.sv - writeback stage: ALU/load merge into the register-file write port
// with an in-order load-result FIFO and a per-register load scoreboard.
module reg_writeback #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  input  logic [ADDR_W-1:0]        alu_rd,
  input  logic [DATA_W-1:0]        alu_data,
  input  logic                     mem_valid,
  input  logic [ADDR_W-1:0]        mem_rd,
  input  logic [DATA_W-1:0]        mem_data,
  output logic                     mem_ready,
  input  logic                     iss_load,
  input  logic [ADDR_W-1:0]        iss_rd,
  output logic [ADDR_W-1:0]        Rd,
  output logic [DATA_W-1:0]        RW,
  output logic                     wr,
  output logic [(1<<ADDR_W)-1:0]   busy
);

  localparam int IDX_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int NREG  = 1 << ADDR_W;

  typedef enum logic [1:0] {SRC_NONE, SRC_ALU, SRC_FIFO, SRC_MEM} src_e;

  logic [ADDR_W-1:0] fifo_rd_q   [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  count;
  logic              fifo_empty, mem_accept, push, pop;
  src_e              src;

  logic              wr_q, wr_d, is_load_q, is_load_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] rw_q, rw_d;
  logic [NREG-1:0]   busy_q, busy_d;

  // Extra pointer bit distinguishes full from empty.
  assign count      = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign mem_ready  = !rst && (count < PTR_W'(FIFO_DEPTH));
  assign mem_accept = mem_valid && mem_ready;

  always_comb begin
    src = SRC_NONE;
    if (alu_valid)        src = SRC_ALU;
    else if (!fifo_empty) src = SRC_FIFO;
    else if (mem_accept)  src = SRC_MEM;
  end

  assign push = mem_accept && (src != SRC_MEM);
  assign pop  = (src == SRC_FIFO);

  always_comb begin
    wr_ptr_d  = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_d      = 1'b0;
    rd_d      = rd_q;
    rw_d      = rw_q;
    is_load_d = is_load_q;
    unique case (src)
      SRC_ALU: begin
        wr_d = 1'b1; rd_d = alu_rd; rw_d = alu_data; is_load_d = 1'b0;
      end
      SRC_FIFO: begin
        wr_d      = 1'b1;
        rd_d      = fifo_rd_q[rd_ptr_q[IDX_W-1:0]];
        rw_d      = fifo_data_q[rd_ptr_q[IDX_W-1:0]];
        is_load_d = 1'b1;
      end
      SRC_MEM: begin
        wr_d = 1'b1; rd_d = mem_rd; rw_d = mem_data; is_load_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Clear when the load write retires; a same-cycle issue to that register wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_q && is_load_q) busy_d[rd_q] = 1'b0;
    if (iss_load)          busy_d[iss_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      wr_q      <= 1'b0;
      rd_q      <= '0;
      rw_q      <= '0;
      is_load_q <= 1'b0;
      busy_q    <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      rw_q      <= rw_d;
      is_load_q <= is_load_d;
      busy_q    <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q[IDX_W-1:0]]   <= mem_rd;
      fifo_data_q[wr_ptr_q[IDX_W-1:0]] <= mem_data;
    end
  end

  assign Rd   = rd_q;
  assign RW   = rw_q;
  assign wr   = wr_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_reg_writeback.sv
// tb/tb_reg_writeback.sv - self-checking bench for reg_writeback: directed vector table,
// mid-operation reset sequence and randomized traffic against a queue-based reference model.
module tb_reg_writeback;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, alu_valid, mem_valid, iss_load, mem_ready, wr;
  logic [3:0]  alu_rd, mem_rd, iss_rd, Rd;
  logic [15:0] alu_data, mem_data, RW, busy;

  reg_writeback #(.DATA_W(16), .ADDR_W(4), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .iss_load(iss_load), .iss_rd(iss_rd),
    .Rd(Rd), .RW(RW), .wr(wr), .busy(busy)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: pending load results in arrival order, plus the visible write port.
  typedef struct {
    logic [3:0]  rd;
    logic [15:0] data;
  } ent_t;
  ent_t        m_q[$];
  logic        m_wr = 1'b0, m_isl = 1'b0;
  logic [3:0]  m_rd = '0;
  logic [15:0] m_rw = '0, m_busy = '0;

  typedef struct {
    logic        r, av;
    logic [3:0]  ard;
    logic [15:0] ad;
    logic        mv;
    logic [3:0]  mrd;
    logic [15:0] md;
    logic        il;
    logic [3:0]  ird;
    logic        e_ready, e_wr;
    logic [3:0]  e_rd;
    logic [15:0] e_rw, e_busy;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic av, input logic [3:0] ard, input logic [15:0] ad,
                       input logic mv, input logic [3:0] mrd, input logic [15:0] md,
                       input logic il, input logic [3:0] ird);
    rst = r; alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md; iss_load = il; iss_rd = ird;
  endtask

  // One clock: check mem_ready, advance the model, then check registered outputs.
  task automatic step();
    logic        acc;
    logic [15:0] nb;
    ent_t        e;
    #1;
    chk("mem_ready", {31'b0, mem_ready}, {31'b0, (!rst && m_q.size() < DEPTH)});
    if (rst) begin
      m_q.delete();
      m_wr = 1'b0; m_isl = 1'b0; m_rd = '0; m_rw = '0; m_busy = '0;
    end else begin
      acc = mem_valid && (m_q.size() < DEPTH);
      nb = m_busy;
      if (m_wr && m_isl) nb[m_rd] = 1'b0;
      if (iss_load) nb[iss_rd] = 1'b1;
      if (alu_valid) begin
        m_wr = 1'b1; m_rd = alu_rd; m_rw = alu_data; m_isl = 1'b0;
      end else if (m_q.size() > 0) begin
        e = m_q.pop_front();
        m_wr = 1'b1; m_rd = e.rd; m_rw = e.data; m_isl = 1'b1;
      end else if (acc) begin
        m_wr = 1'b1; m_rd = mem_rd; m_rw = mem_data; m_isl = 1'b1;
        acc = 1'b0;
      end else begin
        m_wr = 1'b0;
      end
      if (acc) m_q.push_back('{rd: mem_rd, data: mem_data});
      m_busy = nb;
    end
    @(posedge clk);
    #1;
    chk("wr", {31'b0, wr}, {31'b0, m_wr});
    chk("Rd", {28'b0, Rd}, {28'b0, m_rd});
    chk("RW", {16'b0, RW}, {16'b0, m_rw});
    chk("busy", {16'b0, busy}, {16'b0, m_busy});
  endtask

  task automatic add(input logic r, input logic av, input logic [3:0] ard, input logic [15:0] ad,
                     input logic mv, input logic [3:0] mrd, input logic [15:0] md,
                     input logic il, input logic [3:0] ird,
                     input logic er, input logic ew, input logic [3:0] erd,
                     input logic [15:0] erw, input logic [15:0] eb);
    vecs.push_back('{r, av, ard, ad, mv, mrd, md, il, ird, er, ew, erd, erw, eb});
  endtask

  task automatic idle_row(input logic ew, input logic [3:0] erd, input logic [15:0] erw,
                          input logic [15:0] eb);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, ew, erd, erw, eb);
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset with all inputs active
    add(1, 1, 1, 16'h1111, 1, 2, 16'h2222, 1, 2,   0, 0, 0, 16'h0000, 16'h0000);
    add(1, 1, 1, 16'h1111, 1, 2, 16'h2222, 1, 2,   0, 0, 0, 16'h0000, 16'h0000);
    // ALU path
    add(0, 1, 3, 16'h1234, 0, 0, 0, 0, 0,          1, 1, 3, 16'h1234, 16'h0000);
    idle_row(0, 3, 16'h1234, 16'h0000);
    // Load bypass and scoreboard
    add(0, 0, 0, 0, 0, 0, 0, 1, 7,                 1, 0, 3, 16'h1234, 16'h0080);
    idle_row(0, 3, 16'h1234, 16'h0080);
    idle_row(0, 3, 16'h1234, 16'h0080);
    idle_row(0, 3, 16'h1234, 16'h0080);
    add(0, 0, 0, 0, 1, 7, 16'hBEEF, 0, 0,          1, 1, 7, 16'hBEEF, 16'h0080);
    idle_row(0, 7, 16'hBEEF, 16'h0000);
    // Same-index set and clear: set wins
    add(0, 0, 0, 0, 0, 0, 0, 1, 5,                 1, 0, 7, 16'hBEEF, 16'h0020);
    add(0, 0, 0, 0, 1, 5, 16'h5555, 0, 0,          1, 1, 5, 16'h5555, 16'h0020);
    add(0, 0, 0, 0, 0, 0, 0, 1, 5,                 1, 0, 5, 16'h5555, 16'h0020);
    add(0, 0, 0, 0, 1, 5, 16'h6666, 0, 0,          1, 1, 5, 16'h6666, 16'h0020);
    idle_row(0, 5, 16'h6666, 16'h0000);
    // Register 0 is an ordinary destination
    add(0, 1, 0, 16'hA5A5, 0, 0, 0, 0, 0,          1, 1, 0, 16'hA5A5, 16'h0000);
    // Contention: six ALU cycles while loads A..E are offered
    add(0, 1, 1, 16'h1001, 1, 8,  16'hAAAA, 0, 0,  1, 1, 1,  16'h1001, 16'h0000);
    add(0, 1, 2, 16'h1002, 1, 9,  16'hBBBB, 0, 0,  1, 1, 2,  16'h1002, 16'h0000);
    add(0, 1, 3, 16'h1003, 1, 10, 16'hCCCC, 0, 0,  1, 1, 3,  16'h1003, 16'h0000);
    add(0, 1, 4, 16'h1004, 1, 11, 16'hDDDD, 0, 0,  1, 1, 4,  16'h1004, 16'h0000);
    add(0, 1, 5, 16'h1005, 1, 12, 16'hEEEE, 0, 0,  0, 1, 5,  16'h1005, 16'h0000);
    add(0, 1, 6, 16'h1006, 1, 12, 16'hEEEE, 0, 0,  0, 1, 6,  16'h1006, 16'h0000);
    add(0, 0, 0, 0,        1, 12, 16'hEEEE, 0, 0,  0, 1, 8,  16'hAAAA, 16'h0000);
    add(0, 0, 0, 0,        1, 12, 16'hEEEE, 0, 0,  1, 1, 9,  16'hBBBB, 16'h0000);
    idle_row(1, 10, 16'hCCCC, 16'h0000);
    idle_row(1, 11, 16'hDDDD, 16'h0000);
    idle_row(1, 12, 16'hEEEE, 16'h0000);
    idle_row(0, 12, 16'hEEEE, 16'h0000);

    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].av, vecs[i].ard, vecs[i].ad, vecs[i].mv, vecs[i].mrd,
            vecs[i].md, vecs[i].il, vecs[i].ird);
      #1;
      chk($sformatf("tbl%0d_ready", i), {31'b0, mem_ready}, {31'b0, vecs[i].e_ready});
      step();
      chk($sformatf("tbl%0d_wr", i), {31'b0, wr}, {31'b0, vecs[i].e_wr});
      chk($sformatf("tbl%0d_Rd", i), {28'b0, Rd}, {28'b0, vecs[i].e_rd});
      chk($sformatf("tbl%0d_RW", i), {16'b0, RW}, {16'b0, vecs[i].e_rw});
      chk($sformatf("tbl%0d_busy", i), {16'b0, busy}, {16'b0, vecs[i].e_busy});
    end

    // Mid-operation reset with three queued loads and pending busy bits
    drive(0, 1, 1, 16'h0101, 1, 2, 16'h0202, 1, 2); step();
    drive(0, 1, 1, 16'h0111, 1, 3, 16'h0303, 1, 3); step();
    drive(0, 1, 1, 16'h0121, 1, 4, 16'h0404, 0, 0); step();
    chk("pre_rst_busy", {16'b0, busy}, 32'h0000_000C);
    drive(1, 1, 1, 16'h0131, 1, 5, 16'h0505, 1, 6); step();
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("post_rst_ready", {31'b0, mem_ready}, 32'h1);
      step();
      chk("post_rst_wr", {31'b0, wr}, 32'h0);
      chk("post_rst_busy", {16'b0, busy}, 32'h0);
    end

    // Randomized traffic, alternating ALU-heavy and light phases
    for (int c = 0; c < 1200; c++) begin
      int          alu_pct;
      logic        il;
      logic [3:0]  ird;
      alu_pct = ((c / 100) % 2 == 0) ? 90 : 30;
      il  = 1'b0;
      ird = '0;
      if (m_busy != 16'hFFFF && $urandom_range(0, 3) == 0) begin
        il = 1'b1;
        do ird = 4'($urandom_range(0, 15)); while (m_busy[ird]);
      end
      drive(($urandom_range(0, 99) == 0),
            ($urandom_range(0, 99) < alu_pct), 4'($urandom_range(0, 15)), 16'($urandom),
            ($urandom_range(0, 9) < 6), 4'($urandom_range(0, 15)), 16'($urandom),
            il, ird);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
